// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit buffer.
package uart_pkg;

  localparam int UART_W           = 8;
  localparam int BUSY_TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level and flags; storage read combinationally at the head.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK_SYS,
  input  logic                  CLK_RST,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic                  push;
  logic                  pop;

  // A write while full is rejected even if a pop frees a slot this cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_nxt;
      full     <= (level_nxt == LEVEL_FULL);
      empty    <= (level_nxt == '0);
      overflow <= wr_en && full;
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue feeding UART_SEND: pops one byte at a time and runs the level-enable/busy handshake.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                CLK_SYS,
  input  logic                CLK_RST,
  input  logic                wr_en,
  input  logic [UART_W-1:0]   wr_data,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic [DEPTH_LOG2:0] fifo_level,
  output logic                overflow,
  output logic                uart_tx_en,
  output logic [UART_W-1:0]   uart_din,
  input  logic                uart_tx_busy,
  output logic                tx_done,
  output logic                timeout_err
);

  // state | meaning
  // IDLE  | waiting for a queued byte; pops it and raises uart_tx_en
  // REQ   | uart_tx_en high, waiting for the sender to raise busy (timed)
  // WAIT  | byte accepted, uart_din held until busy falls

  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam logic [TW-1:0] TCNT_LOAD = TW'(BUSY_TIMEOUT - 1);

  tx_state_t         state, state_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic              en_nxt;
  logic [UART_W-1:0] din_nxt;
  logic              done_nxt;
  logic              to_nxt;
  logic              pop;
  logic [UART_W-1:0] head;

  sync_fifo #(
    .WIDTH      (UART_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK_SYS  (CLK_SYS),
    .CLK_RST  (CLK_RST),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .overflow (overflow)
  );

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    en_nxt    = uart_tx_en;
    din_nxt   = uart_din;
    done_nxt  = 1'b0;
    to_nxt    = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          din_nxt   = head;
          en_nxt    = 1'b1;
          tcnt_nxt  = TCNT_LOAD;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // A busy already high on entry counts as acceptance.
        if (uart_tx_busy) begin
          en_nxt    = 1'b0;
          state_nxt = S_WAIT;
        end else if (tcnt == '0) begin
          en_nxt    = 1'b0;
          to_nxt    = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tcnt_nxt = tcnt - 1'b1;
        end
      end
      S_WAIT: begin
        if (!uart_tx_busy) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        en_nxt    = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      uart_tx_en  <= 1'b0;
      uart_din    <= '0;
      tx_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      uart_tx_en  <= en_nxt;
      uart_din    <= din_nxt;
      tx_done     <= done_nxt;
      timeout_err <= to_nxt;
    end
  end

endmodule
